// File: rtl/core_n_ex.sv
// core_n_ex: parametrised execution core with register file, ALU and an
// execution FSM. Instructions are accepted over a valid/ready handshake.
// MUL is an iterative shift-add that takes DW cycles after decode.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   inst            16-bit instruction: [15:12] op, [7:4] rd, [3:0] rs,
//                   imm8 = {inst[11:8], inst[3:0]}
//   inst_valid      instruction offered this cycle
//   inst_ready      core is idle and will take the instruction
//   retire          1-cycle pulse: the instruction commits at the next edge
//   illegal         1-cycle pulse with retire for illegal instructions
//   flags           {C,Z,V,N}
//   dbg_sel         debug register index
//   dbg_data        committed contents of register dbg_sel
//
// state | meaning
// IDLE  | waiting for an instruction, inst_ready=1
// EXEC  | IR decoded, operands read, single-cycle ops commit
// MULT  | one shift-add step per cycle, commit when counter reaches 0
module core_n_ex #(
  parameter int DW     = 8,
  parameter int NREG   = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               inst,
  input  logic                      inst_valid,
  output logic                      inst_ready,
  output logic                      retire,
  output logic                      illegal,
  output logic [3:0]                flags,
  input  logic [$clog2(NREG)-1:0]   dbg_sel,
  output logic [DW-1:0]             dbg_data
);
  localparam int RW   = $clog2(NREG);
  localparam int NPHY = 1 << RW;
  localparam int CW   = $clog2(DW);

  localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4, OP_SUB = 4'h5, OP_MOV = 4'h6, OP_ANDI = 4'h7;
  localparam logic [3:0] OP_ORI = 4'h8, OP_SUBI = 4'h9, OP_MUL = 4'hA, OP_LDI = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULT} state_t;

  state_t          state, state_nx;
  logic [15:0]     ir;
  logic [DW-1:0]   regs [NPHY];
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   acc, mshift, mcand;

  logic [3:0]      op, rd, rs;
  logic [RW-1:0]   rd_i, rs_i;
  logic [DW-1:0]   r_val, s_val, imm, sub_b, logic_res;
  logic [DW:0]     add_res, sub_res, mul_sum;
  logic [2*DW-1:0] mul_step;
  logic            add_cin, v_add, v_sub;
  logic            op_ok, uses_rs, bad;
  logic            wr_en, fl_en, mul_load;
  logic [DW-1:0]   wr_data;
  logic [3:0]      flags_nx;

  assign op    = ir[15:12];
  assign rd    = ir[7:4];
  assign rs    = ir[3:0];
  assign rd_i  = rd[RW-1:0];
  assign rs_i  = rs[RW-1:0];
  assign r_val = regs[rd_i];
  assign s_val = regs[rs_i];
  assign imm   = DW'({ir[11:8], ir[3:0]});

  assign inst_ready = (state == S_IDLE);
  assign dbg_data   = regs[dbg_sel];

  always_comb begin
    op_ok   = 1'b1;
    uses_rs = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_AND, OP_OR, OP_EOR, OP_SUB, OP_MOV: uses_rs = 1'b1;
      OP_MUL: begin
        uses_rs = 1'b1;
        op_ok   = MUL_EN;
      end
      OP_ANDI, OP_ORI, OP_SUBI, OP_LDI, OP_NOP: ;
      default: op_ok = 1'b0;
    endcase
  end

  // NOP never names a register, so its rd field is don't-care.
  assign bad = !op_ok
             || ((op != OP_NOP) && (32'(rd) >= NREG))
             || (uses_rs && (32'(rs) >= NREG));

  assign add_cin = (op == OP_ADC) & flags[3];
  assign add_res = {1'b0, r_val} + {1'b0, s_val} + {{DW{1'b0}}, add_cin};
  assign v_add   = (r_val[DW-1] == s_val[DW-1]) && (add_res[DW-1] != r_val[DW-1]);
  assign sub_b   = (op == OP_SUBI) ? imm : s_val;
  assign sub_res = {1'b0, r_val} - {1'b0, sub_b};
  assign v_sub   = (r_val[DW-1] != sub_b[DW-1]) && (sub_res[DW-1] != r_val[DW-1]);

  always_comb begin
    logic_res = '0;
    case (op)
      OP_AND:  logic_res = r_val & s_val;
      OP_OR:   logic_res = r_val | s_val;
      OP_EOR:  logic_res = r_val ^ s_val;
      OP_ANDI: logic_res = r_val & imm;
      OP_ORI:  logic_res = r_val | imm;
      default: logic_res = '0;
    endcase
  end

  // {acc, mshift} shifts right each step; the finished product sits in it.
  assign mul_sum  = {1'b0, acc} + {1'b0, (mshift[0] ? mcand : {DW{1'b0}})};
  assign mul_step = {mul_sum, mshift[DW-1:1]};

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    illegal  = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    fl_en    = 1'b0;
    flags_nx = flags;
    mul_load = 1'b0;
    case (state)
      S_IDLE: if (inst_valid) state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_IDLE;
        retire   = 1'b1;
        if (bad) begin
          illegal = 1'b1;
        end else begin
          case (op)
            OP_ADD, OP_ADC: begin
              wr_en    = 1'b1;
              wr_data  = add_res[DW-1:0];
              fl_en    = 1'b1;
              flags_nx = {add_res[DW], ~|add_res[DW-1:0], v_add, add_res[DW-1]};
            end
            OP_SUB, OP_SUBI: begin
              wr_en    = 1'b1;
              wr_data  = sub_res[DW-1:0];
              fl_en    = 1'b1;
              flags_nx = {sub_res[DW], ~|sub_res[DW-1:0], v_sub, sub_res[DW-1]};
            end
            OP_AND, OP_OR, OP_EOR, OP_ANDI, OP_ORI: begin
              wr_en    = 1'b1;
              wr_data  = logic_res;
              fl_en    = 1'b1;
              flags_nx = {flags[3], ~|logic_res, 1'b0, logic_res[DW-1]};
            end
            OP_MOV: begin
              wr_en   = 1'b1;
              wr_data = s_val;
            end
            OP_LDI: begin
              wr_en   = 1'b1;
              wr_data = imm;
            end
            OP_MUL: begin
              retire   = 1'b0;
              mul_load = 1'b1;
              state_nx = S_MULT;
            end
            default: ;
          endcase
        end
      end
      S_MULT: begin
        if (cnt == '0) begin
          retire   = 1'b1;
          wr_en    = 1'b1;
          wr_data  = mul_step[DW-1:0];
          fl_en    = 1'b1;
          flags_nx = {|mul_step[2*DW-1:DW], ~|mul_step[DW-1:0], 1'b0, mul_step[DW-1]};
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ir     <= '0;
      flags  <= '0;
      cnt    <= '0;
      acc    <= '0;
      mshift <= '0;
      mcand  <= '0;
      for (int i = 0; i < NPHY; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (inst_valid && inst_ready) ir <= inst;
      if (wr_en) regs[rd_i] <= wr_data;
      if (fl_en) flags <= flags_nx;
      if (mul_load) begin
        cnt    <= CW'(DW - 1);
        acc    <= '0;
        mshift <= s_val;
        mcand  <= r_val;
      end else if (state == S_MULT) begin
        cnt           <= cnt - CW'(1);
        {acc, mshift} <= mul_step;
      end
    end
  end
endmodule

// File: tb/tb_core_n_ex.sv
module tb_core_n_ex;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] inst_a, inst_b;
  logic        valid_a, valid_b;
  logic        ready_a, retire_a, illegal_a, ready_b, retire_b, illegal_b;
  logic [3:0]  flags_a, flags_b;
  logic [1:0]  sel_a;
  logic [3:0]  sel_b;
  logic [7:0]  dbg_a;
  logic [15:0] dbg_b;

  core_n_ex #(.DW(8), .NREG(4), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .inst(inst_a), .inst_valid(valid_a), .inst_ready(ready_a),
    .retire(retire_a), .illegal(illegal_a), .flags(flags_a), .dbg_sel(sel_a), .dbg_data(dbg_a)
  );

  core_n_ex #(.DW(16), .NREG(16), .MUL_EN(1'b0)) u_dut16 (
    .clk(clk), .rst(rst), .inst(inst_b), .inst_valid(valid_b), .inst_ready(ready_b),
    .retire(retire_b), .illegal(illegal_b), .flags(flags_b), .dbg_sel(sel_b), .dbg_data(dbg_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          b;
    logic [15:0] i;
    logic        ill;
    logic [3:0]  idx;
    logic [31:0] val;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit b, logic [15:0] i, logic ill, logic [3:0] idx,
                              logic [31:0] val, logic [3:0] fl);
    vec_t v;
    v.b = b; v.i = i; v.ill = ill; v.idx = idx; v.val = val; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic peek(input bit b, input logic [3:0] idx, output logic [31:0] v);
    if (b) sel_b = idx;
    else   sel_a = idx[1:0];
    #1;
    v = b ? {16'h0, dbg_b} : {24'h0, dbg_a};
  endtask

  task automatic send(input bit b, input logic [15:0] i, output int lat, output logic ill);
    @(negedge clk);
    if (b) begin inst_b = i; valid_b = 1'b1; end
    else   begin inst_a = i; valid_a = 1'b1; end
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    lat = 0;
    ill = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (b ? retire_b : retire_a) begin
        lat = n;
        ill = b ? illegal_b : illegal_a;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat, rdy_hi, ret_seen;
    logic        ill;
    logic [31:0] v;

    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
    inst_a = '0; inst_b = '0; sel_a = '0; sel_b = '0;

    // 8-bit, 4 registers
    vecs.push_back(mk(0, 16'hE51A, 0, 1, 32'h5A, 4'b0000)); // LDI R1,5A
    vecs.push_back(mk(0, 16'hEF0F, 0, 0, 32'hFF, 4'b0000)); // LDI R0,FF
    vecs.push_back(mk(0, 16'hE011, 0, 1, 32'h01, 4'b0000)); // LDI R1,01
    vecs.push_back(mk(0, 16'h0001, 0, 0, 32'h00, 4'b1100)); // ADD R0,R1
    vecs.push_back(mk(0, 16'h1001, 0, 0, 32'h02, 4'b0000)); // ADC R0,R1
    vecs.push_back(mk(0, 16'hE820, 0, 2, 32'h80, 4'b0000)); // LDI R2,80
    vecs.push_back(mk(0, 16'hE031, 0, 3, 32'h01, 4'b0000)); // LDI R3,01
    vecs.push_back(mk(0, 16'h5023, 0, 2, 32'h7F, 4'b0010)); // SUB R2,R3
    vecs.push_back(mk(0, 16'h9032, 0, 3, 32'hFF, 4'b1001)); // SUBI R3,02
    vecs.push_back(mk(0, 16'hB000, 1, 0, 32'h02, 4'b1001)); // reserved op
    vecs.push_back(mk(0, 16'h0050, 1, 3, 32'hFF, 4'b1001)); // ADD R5,R0
    vecs.push_back(mk(0, 16'h2023, 0, 2, 32'h7F, 4'b1000)); // AND R2,R3
    vecs.push_back(mk(0, 16'h4033, 0, 3, 32'h00, 4'b1100)); // EOR R3,R3
    vecs.push_back(mk(0, 16'h3032, 0, 3, 32'h7F, 4'b1000)); // OR R3,R2
    vecs.push_back(mk(0, 16'h6002, 0, 0, 32'h7F, 4'b1000)); // MOV R0,R2
    vecs.push_back(mk(0, 16'h700F, 0, 0, 32'h0F, 4'b1000)); // ANDI R0,0F
    vecs.push_back(mk(0, 16'h8F00, 0, 0, 32'hFF, 4'b1001)); // ORI R0,F0
    vecs.push_back(mk(0, 16'hF000, 0, 0, 32'hFF, 4'b1001)); // NOP
    vecs.push_back(mk(0, 16'h5011, 0, 1, 32'h00, 4'b0100)); // SUB R1,R1
    vecs.push_back(mk(0, 16'h6007, 1, 0, 32'hFF, 4'b0100)); // MOV R0,R7
    // 16-bit, 16 registers, no MUL
    vecs.push_back(mk(1, 16'hEF0F, 0, 0, 32'h00FF, 4'b0000));
    vecs.push_back(mk(1, 16'hE011, 0, 1, 32'h0001, 4'b0000));
    vecs.push_back(mk(1, 16'h0001, 0, 0, 32'h0100, 4'b0000));
    vecs.push_back(mk(1, 16'h1001, 0, 0, 32'h0101, 4'b0000));
    vecs.push_back(mk(1, 16'hE820, 0, 2, 32'h0080, 4'b0000));
    vecs.push_back(mk(1, 16'hE031, 0, 3, 32'h0001, 4'b0000));
    vecs.push_back(mk(1, 16'h5023, 0, 2, 32'h007F, 4'b0000));
    vecs.push_back(mk(1, 16'h9032, 0, 3, 32'hFFFF, 4'b1001));
    vecs.push_back(mk(1, 16'hA012, 1, 1, 32'h0001, 4'b1001)); // MUL illegal
    vecs.push_back(mk(1, 16'h0050, 0, 5, 32'h0101, 4'b0000)); // ADD R5,R0

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst ready", {31'h0, ready_a}, 32'h1);
    chk("rst retire", {31'h0, retire_a}, 32'h0);
    chk("rst illegal", {31'h0, illegal_a}, 32'h0);
    chk("rst flags", {28'h0, flags_a}, 32'h0);
    chk("rst ready16", {31'h0, ready_b}, 32'h1);
    for (int r = 0; r < 4; r++) begin
      peek(0, 4'(r), v);
      chk($sformatf("rst R%0d", r), v, 32'h0);
    end

    foreach (vecs[k]) begin
      send(vecs[k].b, vecs[k].i, lat, ill);
      chk($sformatf("v%0d latency", k), lat, 1);
      chk($sformatf("v%0d illegal", k), {31'h0, ill}, {31'h0, vecs[k].ill});
      peek(vecs[k].b, vecs[k].idx, v);
      chk($sformatf("v%0d R%0d", k, vecs[k].idx), v, vecs[k].val);
      chk($sformatf("v%0d flags", k), {28'h0, (vecs[k].b ? flags_b : flags_a)}, {28'h0, vecs[k].fl});
    end

    // MUL R1,R2 with a held instruction that must not be taken during MULT
    send(0, 16'hE110, lat, ill);
    send(0, 16'hE121, lat, ill);
    @(negedge clk);
    inst_a = 16'hA012; valid_a = 1'b1;
    @(posedge clk);
    #1 inst_a = 16'hE303;
    lat = 0; rdy_hi = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (ready_a) rdy_hi++;
      if (retire_a) begin
        lat = n;
        valid_a = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("mul latency", lat, 9);
    chk("mul ready during MULT", rdy_hi, 0);
    chk("mul back to idle", {31'h0, ready_a}, 32'h1);
    peek(0, 4'd1, v);
    chk("mul R1", v, 32'h10);
    chk("mul flags", {28'h0, flags_a}, 32'b1000);
    peek(0, 4'd0, v);
    chk("held inst ignored R0", v, 32'hFF);

    // reset in MULT cycle 3 aborts the MUL
    @(negedge clk);
    inst_a = 16'hA012; valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
    ret_seen = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (retire_a) ret_seen++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort no retire", ret_seen, 0);
    chk("abort ready", {31'h0, ready_a}, 32'h1);
    chk("abort flags", {28'h0, flags_a}, 32'h0);
    for (int r = 0; r < 4; r++) begin
      peek(0, 4'(r), v);
      chk($sformatf("abort R%0d", r), v, 32'h0);
    end
    ret_seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (retire_a) ret_seen++;
    end
    chk("abort later retire", ret_seen, 0);

    send(0, 16'hE51A, lat, ill);
    chk("post-abort latency", lat, 1);
    peek(0, 4'd1, v);
    chk("post-abort R1", v, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
